seq_stream_ctrl: RTL

Frame-level controller for the serial pattern-detector datapath. It accepts parallel words over a valid/ready handshake and serializes them MSB-first onto `datain`. It runs a programmable, overlapping pattern match on the stream, pulses `yes` per match, counts matches per frame, and signals frame completion. It sits between a word-oriented producer and the bit-serial detection path, and replaces hand-driven `datain` stimulus.

---
 rtl/seq_stream_pkg.sv | 16 +
 rtl/seq_match_core.sv | 49 ++++
 rtl/seq_stream_ctrl.sv | 113 +++++++++++
 3 files changed

// File: rtl/seq_stream_pkg.sv
// Shared types and default sizes for the serial stream controller and its
// pattern-match core.
package seq_stream_pkg;

  localparam int unsigned WORD_W_DEF = 8;
  localparam int unsigned PAT_W_DEF  = 4;
  localparam int unsigned CNT_W_DEF  = 8;
  localparam int unsigned STATE_W    = 2;

  typedef enum logic [STATE_W-1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    WAIT  = 2'd2
  } state_t;

endpackage

// File: rtl/seq_match_core.sv
// Overlapping serial pattern matcher: history shift register, saturating fill
// counter, comparator and registered match pulse.
module seq_match_core
  import seq_stream_pkg::*;
#(
  parameter int unsigned PAT_W = PAT_W_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  input  logic             bit_valid,
  input  logic             bit_in,
  input  logic [PAT_W-1:0] pattern,
  output logic             hit,
  output logic             yes
);

  localparam int unsigned FW = $clog2(PAT_W + 1);

  logic [PAT_W-1:0] hist, hist_nxt;
  logic [FW-1:0]    fill, fill_nxt;

  // hit is the combinational view of the match so the owner can count it on
  // the same edge that registers yes.
  always_comb begin
    hist_nxt = {hist[PAT_W-2:0], bit_in};
    fill_nxt = (fill == FW'(PAT_W)) ? fill : fill + FW'(1);
    hit      = bit_valid && (fill_nxt == FW'(PAT_W)) && (hist_nxt == pattern);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      hist <= '0;
      fill <= '0;
      yes  <= 1'b0;
    end else if (clear) begin
      hist <= '0;
      fill <= '0;
      yes  <= 1'b0;
    end else begin
      yes <= hit;
      if (bit_valid) begin
        hist <= hist_nxt;
        fill <= fill_nxt;
      end
    end
  end

endmodule

// File: rtl/seq_stream_ctrl.sv
// Frame controller: serializes handshaked words MSB-first and counts pattern
// matches per frame. Define SEQ_STREAM_CTRL_SAT_EN to saturate match_cnt.
module seq_stream_ctrl
  import seq_stream_pkg::*;
#(
  parameter int unsigned WORD_W = WORD_W_DEF,
  parameter int unsigned PAT_W  = PAT_W_DEF,
  parameter int unsigned CNT_W  = CNT_W_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              pat_load,
  input  logic [PAT_W-1:0]  pat_in,
  input  logic              word_valid,
  input  logic [WORD_W-1:0] word_data,
  input  logic              word_last,
  output logic              word_ready,
  output logic              datain,
  output logic              bit_valid,
  output logic              yes,
  output logic [CNT_W-1:0]  match_cnt,
  output logic              frame_done,
  output logic              busy
);

  localparam int unsigned BW = (WORD_W > 1) ? $clog2(WORD_W) : 1;

  state_t            state, state_nxt;
  logic [WORD_W-1:0] sreg;
  logic [BW-1:0]     bidx;
  logic              last_q;
  logic [PAT_W-1:0]  pattern;
  logic              final_bit, accept, start, hit;

  assign final_bit = (state == SHIFT) && (bidx == '0);
  assign accept    = word_valid && word_ready;
  assign start     = accept && (state == IDLE);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:  if (accept) state_nxt = SHIFT;
      SHIFT: if (final_bit) begin
               if (last_q)      state_nxt = IDLE;
               else if (accept) state_nxt = SHIFT;
               else             state_nxt = WAIT;
             end
      WAIT:  if (accept) state_nxt = SHIFT;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    word_ready = reset && ((state == IDLE) || (state == WAIT) || (final_bit && !last_q));
    busy       = (state != IDLE);
    bit_valid  = (state == SHIFT);
    datain     = bit_valid && sreg[WORD_W-1];
  end

  // A word accepted on the final bit reloads the serializer directly, so
  // back-to-back words stream without a bubble.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sreg   <= '0;
      bidx   <= '0;
      last_q <= 1'b0;
    end else if (accept) begin
      sreg   <= word_data;
      bidx   <= BW'(WORD_W - 1);
      last_q <= word_last;
    end else if (bit_valid) begin
      sreg   <= {sreg[WORD_W-2:0], 1'b0};
      bidx   <= bidx - BW'(1);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pattern    <= '0;
      frame_done <= 1'b0;
      match_cnt  <= '0;
    end else begin
      if (pat_load && (state == IDLE)) pattern <= pat_in;
      frame_done <= final_bit && last_q;
      if (start) begin
        match_cnt <= '0;
      end else if (hit) begin
`ifdef SEQ_STREAM_CTRL_SAT_EN
        if (match_cnt != '1) match_cnt <= match_cnt + CNT_W'(1);
`else
        match_cnt <= match_cnt + CNT_W'(1);
`endif
      end
    end
  end

  seq_match_core #(.PAT_W(PAT_W)) u_core (
    .clk       (clk),
    .reset     (reset),
    .clear     (start),
    .bit_valid (bit_valid),
    .bit_in    (datain),
    .pattern   (pattern),
    .hit       (hit),
    .yes       (yes)
  );

endmodule
